debug_mem_dumper: RTL

- Debug-unit side reader of the data memory's debug port.
- On a start pulse it takes ownership of the memory's debug address mux and walks addresses 0..N_WORDS-1.
- For each address it latches the returned word and streams it byte-by-byte, LSB first, to the UART transmitter through a start/done handshake.
- After the last word it sends one status byte carrying the memory dirty bit, then releases the port.
- Sits between the data memory stage (debug address/data port) and the debug unit's UART TX.

---
 rtl/debug_mem_dumper_if.sv | 31 +++
 rtl/debug_mem_dumper.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/debug_mem_dumper_if.sv
// debug_mem_dumper_if: memory debug port and UART TX handshake seen by the dumper.
// master = dumper side, slave = memory/UART/debug-unit side.
interface debug_mem_dumper_if #(
  parameter int NB_DATA   = 32,
  parameter int ADDRWIDTH = 10,
  parameter int NB_BYTE   = 8
);
  logic                 i_start;
  logic [NB_DATA-1:0]   i_data_mem_debug_unit;
  logic                 i_bit_sucio;
  logic                 i_tx_done;
  logic [ADDRWIDTH-1:0] o_addr_mem_debug_unit;
  logic                 o_ctrl_addr_debug_mem;
  logic                 o_ctrl_wr_debug_mem;
  logic [NB_BYTE-1:0]   o_tx_data;
  logic                 o_tx_start;
  logic                 o_busy;
  logic                 o_done;

  modport master (
    input  i_start, i_data_mem_debug_unit, i_bit_sucio, i_tx_done,
    output o_addr_mem_debug_unit, o_ctrl_addr_debug_mem, o_ctrl_wr_debug_mem,
           o_tx_data, o_tx_start, o_busy, o_done
  );

  modport slave (
    output i_start, i_data_mem_debug_unit, i_bit_sucio, i_tx_done,
    input  o_addr_mem_debug_unit, o_ctrl_addr_debug_mem, o_ctrl_wr_debug_mem,
           o_tx_data, o_tx_start, o_busy, o_done
  );
endinterface

// File: rtl/debug_mem_dumper.sv
// debug_mem_dumper: walks the data memory debug port and streams every word LSB-first over UART, then a dirty-bit status byte.
// Optional DUMP_ADDR_TAG_EN: precede each word with a byte holding the low address bits.
module debug_mem_dumper #(
  parameter int NB_DATA   = 32,
  parameter int ADDRWIDTH = 10,
  parameter int NB_BYTE   = 8,
  parameter int N_WORDS   = 32
) (
  input  logic              i_clock,
  input  logic              i_reset,
  debug_mem_dumper_if.master bus
);
  localparam int N_BYTES = NB_DATA / 8;
  localparam int NB_CNT  = $clog2(N_BYTES + 1);
  localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(N_WORDS - 1);
  localparam logic [NB_CNT-1:0]    LAST_BYTE = NB_CNT'(N_BYTES - 1);

  typedef enum logic [3:0] {
    IDLE, SET_ADDR, WAIT_MEM, LATCH,
`ifdef DUMP_ADDR_TAG_EN
    TAG,
`endif
    SEND, WAIT_TX, NEXT, STATUS
  } state_t;

  typedef enum logic [1:0] {K_TAG, K_DATA, K_STAT} kind_t;

  state_t               state_q, state_d;
  kind_t                kind_q, kind_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [NB_DATA-1:0]   shift_q, shift_d;
  logic [NB_CNT-1:0]    byte_cnt_q, byte_cnt_d;
  logic                 status_q, status_d;
  logic [NB_BYTE-1:0]   tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    addr_d     = addr_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    status_d   = status_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    busy_d     = state_q != IDLE;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        // a start arriving alongside o_done is dropped so a restart needs a fresh pulse
        if (bus.i_start && !done_q) begin
          addr_d   = '0;
          status_d = bus.i_bit_sucio;
          state_d  = SET_ADDR;
        end
      end
      SET_ADDR: state_d = WAIT_MEM;
      WAIT_MEM: state_d = LATCH;
      LATCH: begin
        shift_d    = bus.i_data_mem_debug_unit;
        byte_cnt_d = '0;
`ifdef DUMP_ADDR_TAG_EN
        state_d    = TAG;
`else
        state_d    = SEND;
`endif
      end
`ifdef DUMP_ADDR_TAG_EN
      TAG: begin
        tx_data_d  = NB_BYTE'(addr_q);
        tx_start_d = 1'b1;
        kind_d     = K_TAG;
        state_d    = WAIT_TX;
      end
`endif
      SEND: begin
        tx_data_d  = shift_q[NB_BYTE-1:0];
        tx_start_d = 1'b1;
        kind_d     = K_DATA;
        state_d    = WAIT_TX;
      end
      WAIT_TX: begin
        if (bus.i_tx_done) begin
          case (kind_q)
            K_DATA: begin
              shift_d    = shift_q >> NB_BYTE;
              byte_cnt_d = byte_cnt_q + NB_CNT'(1);
              state_d    = (byte_cnt_q == LAST_BYTE) ? NEXT : SEND;
            end
            K_STAT: begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end
            default: state_d = SEND;
          endcase
        end
      end
      NEXT: begin
        state_d = (addr_q == LAST_ADDR) ? STATUS : SET_ADDR;
        addr_d  = (addr_q == LAST_ADDR) ? addr_q : addr_q + ADDRWIDTH'(1);
      end
      STATUS: begin
        tx_data_d  = NB_BYTE'(status_q);
        tx_start_d = 1'b1;
        kind_d     = K_STAT;
        state_d    = WAIT_TX;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      kind_q     <= K_TAG;
      addr_q     <= '0;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      status_q   <= 1'b0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      addr_q     <= addr_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      status_q   <= status_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.o_addr_mem_debug_unit = addr_q;
  assign bus.o_ctrl_addr_debug_mem = busy_q;
  assign bus.o_ctrl_wr_debug_mem   = 1'b0;
  assign bus.o_tx_data             = tx_data_q;
  assign bus.o_tx_start            = tx_start_q;
  assign bus.o_busy                = busy_q;
  assign bus.o_done                = done_q;
endmodule
